// File: rtl/mem_line_responder.sv
// Line-granular backing memory behind a req/ack handshake, one transaction in flight at a time.
// ack_o/data_o are registered off the ACK state, so they land LATENCY edges after capture.
module mem_line_responder #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 512,
  parameter int LATENCY    = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  write_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy_o
);

  localparam int OFF_W = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic                  commit_wr;
  logic                  unused_addr;

  logic [DATA_WIDTH-1:0] memory [0:DEPTH-1];

  // Offset and high address bits are dropped on purpose: lines alias modulo DEPTH.
  assign unused_addr = ^addr_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdat_d  = wdat_q;
    ack_d   = 1'b0;
    rdat_d  = rdat_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(1);
          wr_d    = write_i;
          idx_d   = addr_i[OFF_W +: IDX_W];
          wdat_d  = data_i;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_LAST) state_d = ACK;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ACK: begin
        state_d = IDLE;
        cnt_d   = '0;
        ack_d   = 1'b1;
        if (!wr_q) rdat_d = memory[idx_q];
      end
      default: state_d = IDLE;
    endcase
    // Busy also covers the registered ack cycle, which overlaps state IDLE.
    busy_d = (state_d != IDLE) || (state_q == ACK);
  end

  assign commit_wr = (state_q == BUSY) && (cnt_q == CNT_LAST) && wr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdat_q  <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      rdat_q  <= rdat_d;
    end
  end

  // Storage has no reset; a write landing on a reset edge is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i && commit_wr) memory[idx_q] <= wdat_q;
  end

  assign ack_o  = ack_q;
  assign busy_o = busy_q;
  assign data_o = rdat_q;

endmodule
